// File: rtl/inst_axi_rbridge_if.sv
// Bus bundle for the instruction-side sram-to-AXI read bridge.
// The master modport is the bridge itself; the slave modport is its environment (icache + AXI memory).
interface inst_axi_rbridge_if;
  // sram-like instruction port
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        inst_err;

  // AXI read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  // AXI read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_addr,
    output inst_rdata, inst_addr_ok, inst_data_ok, inst_err,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_addr,
    input  inst_rdata, inst_addr_ok, inst_data_ok, inst_err,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_rbridge.sv
// Single-outstanding bridge from the icache's sram-like read port to an AXI read master.
// Each request becomes one single-beat AR; the last R beat carrying our ID completes it.
module inst_axi_rbridge #(
  parameter logic [3:0] ARID = 4'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_axi_rbridge_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;

  logic        ar_fire;
  logic        r_ours;
  logic        r_done;

  assign ar_fire = arvalid_q & bus.arready;
  // Beats tagged with another ID belong to someone else and never touch our state.
  assign r_ours  = rready_q & bus.rvalid & (bus.rid == ARID);
  assign r_done  = r_ours & bus.rlast;

  // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    size_d    = size_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.inst_req && !bus.inst_wr) begin
          state_d   = S_AR;
          arvalid_d = 1'b1;
          addr_d    = bus.inst_addr;
          size_d    = bus.inst_size;
        end
      end
      S_AR: begin
        if (ar_fire) begin
          state_d   = S_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_R: begin
        if (r_done) begin
          state_d  = S_IDLE;
          rready_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= 32'd0;
      size_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
    end
  end

  // AR channel: address and size come from the latched request so they hold through backpressure.
  assign bus.arid    = ARID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = arvalid_q;

  assign bus.rready  = rready_q;

  // sram-side responses are combinational so the minimum round trip is two cycles.
  assign bus.inst_addr_ok = (state_q == S_AR) & bus.arready;
  assign bus.inst_data_ok = (state_q == S_R) & r_done;
  assign bus.inst_rdata   = bus.rdata;
  assign bus.inst_err     = (state_q == S_R) & r_done & (bus.rresp != 2'b00);

endmodule

// File: tb/tb_inst_axi_rbridge.sv
// Directed bench for inst_axi_rbridge: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_inst_axi_rbridge;

  localparam logic [3:0] TB_ARID = 4'd5;

  logic clk;
  logic rst;
  inst_axi_rbridge_if bus ();

  inst_axi_rbridge #(.ARID(TB_ARID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: is a read in flight, and has its address been handed over yet.
  logic        m_live = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_addr_done = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [1:0]  m_size = 2'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_live      <= 1'b1;
      m_busy      <= 1'b0;
      m_addr_done <= 1'b0;
      m_addr      <= 32'd0;
      m_size      <= 2'd0;
    end else if (m_live) begin
      if (!m_busy) begin
        if (bus.inst_req && !bus.inst_wr) begin
          m_busy      <= 1'b1;
          m_addr_done <= 1'b0;
          m_addr      <= bus.inst_addr;
          m_size      <= bus.inst_size;
        end
      end else if (!m_addr_done) begin
        if (bus.arready) m_addr_done <= 1'b1;
      end else if (bus.rvalid && bus.rlast && bus.rid == TB_ARID) begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic e_arvalid, e_rready, e_addr_ok, e_data_ok, e_err;
      e_arvalid = m_busy && !m_addr_done;
      e_rready  = m_busy && m_addr_done;
      e_addr_ok = e_arvalid && bus.arready;
      e_data_ok = e_rready && bus.rvalid && bus.rlast && (bus.rid == TB_ARID);
      e_err     = e_data_ok && (bus.rresp != 2'b00);
      check("m_arvalid", bus.arvalid, e_arvalid);
      check("m_rready", bus.rready, e_rready);
      check("m_addr_ok", bus.inst_addr_ok, e_addr_ok);
      check("m_data_ok", bus.inst_data_ok, e_data_ok);
      check("m_err", bus.inst_err, e_err);
      if (e_arvalid) begin
        check("m_araddr", bus.araddr, m_addr);
        check("m_arsize", bus.arsize, {1'b0, m_size});
        check("m_arid", bus.arid, TB_ARID);
        check("m_arlen", bus.arlen, 8'd0);
        check("m_arburst", bus.arburst, 2'b01);
        check("m_arlock_cache_prot", {bus.arlock, bus.arcache, bus.arprot}, 9'd0);
      end
      if (e_data_ok) check("m_rdata", bus.inst_rdata, bus.rdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // One read: ar_wait cycles of arready=0 (inst_addr scrambled meanwhile), then r_wait
  // cycles of beats that must not complete the read, then the final beat.
  task automatic read_txn(input logic [31:0] a, input logic [1:0] sz, input int ar_wait,
                          input int r_wait, input logic [31:0] d, input logic [1:0] resp);
    bus.inst_req  = 1'b1;
    bus.inst_wr   = 1'b0;
    bus.inst_addr = a;
    bus.inst_size = sz;
    bus.arready   = (ar_wait == 0);
    neg();
    check("idle_arvalid", bus.arvalid, 0);
    check("idle_rready", bus.rready, 0);
    cyc();
    for (int i = 0; i < ar_wait; i++) begin
      bus.inst_addr = ~a;
      bus.inst_size = 2'd0;
      neg();
      check("arwait_arvalid", bus.arvalid, 1);
      check("arwait_addr_ok", bus.inst_addr_ok, 0);
      check("arwait_araddr", bus.araddr, a);
      cyc();
    end
    bus.arready = 1'b1;
    neg();
    check("ar_addr_ok", bus.inst_addr_ok, 1);
    check("ar_araddr", bus.araddr, a);
    check("ar_arsize", bus.arsize, {1'b0, sz});
    check("ar_arid", bus.arid, TB_ARID);
    check("ar_rready", bus.rready, 0);
    cyc();
    bus.inst_req  = 1'b0;
    bus.arready   = 1'b0;
    bus.inst_addr = 32'h0;
    for (int i = 0; i < r_wait; i++) begin
      // even: foreign-ID last beat; odd: our ID but not last
      bus.rvalid = 1'b1;
      bus.rdata  = 32'hDEAD_0000 | i;
      bus.rlast  = (i % 2 == 0);
      bus.rid    = (i % 2 == 0) ? TB_ARID + 4'd1 : TB_ARID;
      bus.rresp  = 2'b00;
      neg();
      check("rwait_data_ok", bus.inst_data_ok, 0);
      check("rwait_rready", bus.rready, 1);
      cyc();
    end
    bus.rvalid = 1'b1;
    bus.rlast  = 1'b1;
    bus.rid    = TB_ARID;
    bus.rdata  = d;
    bus.rresp  = resp;
    neg();
    check("r_data_ok", bus.inst_data_ok, 1);
    check("r_rdata", bus.inst_rdata, d);
    check("r_err", bus.inst_err, resp != 2'b00);
    cyc();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.inst_req = 1'b0; bus.inst_wr = 1'b0; bus.inst_size = 2'd0; bus.inst_addr = 32'h0;
    bus.arready = 1'b0;
    bus.rid = 4'd0; bus.rdata = 32'h0; bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    cyc();
    neg();
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_rready", bus.rready, 0);
    check("rst_addr_ok", bus.inst_addr_ok, 0);
    check("rst_data_ok", bus.inst_data_ok, 0);
    check("rst_err", bus.inst_err, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Minimum-latency word read: addr_ok in cycle 1, data_ok in cycle 2.
    read_txn(32'h1FC0_0000, 2'd2, 0, 0, 32'h3C08_BFAF, 2'b00);

    // Address backpressure for 3 cycles with inst_addr changing underneath.
    read_txn(32'h1FC0_0100, 2'd1, 3, 0, 32'h1234_5678, 2'b00);

    // Error response: one-cycle data_ok+err, then idle.
    read_txn(32'h0000_0040, 2'd2, 0, 0, 32'hCAFE_F00D, 2'b10);
    neg();
    check("post_err_data_ok", bus.inst_data_ok, 0);
    check("post_err_err", bus.inst_err, 0);
    check("post_err_rready", bus.rready, 0);
    cyc();

    // Foreign-ID and non-last beats are consumed without completing the read.
    read_txn(32'h0000_0080, 2'd0, 1, 4, 32'h0000_00A5, 2'b00);

    // Write requests are ignored.
    bus.inst_req = 1'b1; bus.inst_wr = 1'b1; bus.inst_addr = 32'h0000_1000; bus.inst_size = 2'd2;
    bus.arready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      neg();
      check("wr_arvalid", bus.arvalid, 0);
      check("wr_addr_ok", bus.inst_addr_ok, 0);
      cyc();
    end
    bus.inst_req = 1'b0; bus.inst_wr = 1'b0; bus.arready = 1'b0;

    // Stale R beat while idle is ignored.
    bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.rid = TB_ARID; bus.rdata = 32'h5555_AAAA;
    neg();
    check("stale_data_ok", bus.inst_data_ok, 0);
    check("stale_rready", bus.rready, 0);
    cyc();
    bus.rvalid = 1'b0; bus.rlast = 1'b0;

    // Reset while in R abandons the read.
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_2000; bus.inst_size = 2'd2; bus.arready = 1'b1;
    cyc();
    cyc();
    bus.inst_req = 1'b0; bus.arready = 1'b0;
    neg();
    check("rstR_rready_before", bus.rready, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.rid = TB_ARID; bus.rdata = 32'h0BAD_0BAD;
    neg();
    check("rstR_data_ok", bus.inst_data_ok, 0);
    check("rstR_rready", bus.rready, 0);
    check("rstR_arvalid", bus.arvalid, 0);
    cyc();
    bus.rvalid = 1'b0; bus.rlast = 1'b0;

    // Reset while in AR abandons the address phase.
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_3000; bus.arready = 1'b0;
    cyc();
    neg();
    check("rstAR_arvalid_before", bus.arvalid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.inst_req = 1'b0; bus.arready = 1'b1;
    neg();
    check("rstAR_arvalid", bus.arvalid, 0);
    check("rstAR_addr_ok", bus.inst_addr_ok, 0);
    cyc();
    bus.arready = 1'b0;

    // Back-to-back reads: second request is raised in the idle cycle after the first data_ok.
    read_txn(32'h0000_0004, 2'd2, 0, 0, 32'h1111_0004, 2'b00);
    read_txn(32'h0000_0008, 2'd2, 0, 0, 32'h2222_0008, 2'b00);
    neg();
    check("b2b_idle_rready", bus.rready, 0);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
